// File: rtl/video_readback.sv
// video_readback: AXI read master that fetches a video frame back out of DDR3 in
// fixed 16-beat bursts and writes every beat into a downstream line buffer.
// Latency: one cycle from each accepted AXI read beat to buf_wr_en/buf_wr_data.
// Backpressure: a burst is only requested once buf_space >= 16; R is never stalled.
//
// Ports:
//   core_clk, ddr_rst       clock (rising edge) and asynchronous active-high reset
//   ddr_init_done, rd_en    calibration-done gate and level enable for readback
//   frame_start             one-cycle pulse, restart the frame at AXI_RADDR_BASE
//   buf_space               free words in the downstream buffer
//   axi_ar*, axi_r*         AXI read address / read data channels
//   buf_wr_en, buf_wr_data  registered write port into the downstream buffer
//   frame_done              one-cycle pulse with the last buffer write of a frame
//   rd_err                  sticky burst-length error
//
// Optional: define VIDEO_READBACK_LEN_CHECK_EN to enable the burst-length checker;
// without it rd_err is tied low.

module video_readback #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         MEM_DQ_WIDTH    = 32,
    parameter logic [CTRL_ADDR_WIDTH-1:0] AXI_RADDR_BASE  = '0,
    parameter logic [CTRL_ADDR_WIDTH-1:0] BURST_ADDR_STEP = CTRL_ADDR_WIDTH'(128),
    parameter logic [15:0]                FRAME_BURSTS    = 16'd4096,
    parameter int                         BUF_DEPTH_AW    = 10
) (
    input  logic                         core_clk,
    input  logic                         ddr_rst,
    input  logic                         ddr_init_done,
    input  logic                         rd_en,
    input  logic                         frame_start,
    input  logic [BUF_DEPTH_AW-1:0]      buf_space,
    output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
    output logic [3:0]                   axi_arlen,
    output logic                         axi_arvalid,
    input  logic                         axi_arready,
    input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
    input  logic                         axi_rvalid,
    input  logic                         axi_rlast,
    output logic                         buf_wr_en,
    output logic [MEM_DQ_WIDTH*8-1:0]    buf_wr_data,
    output logic                         frame_done,
    output logic                         rd_err
);

    localparam int DW = MEM_DQ_WIDTH * 8;

    typedef enum logic [3:0] {
        S_IDLE       = 4'b0001,
        S_WAIT_SPACE = 4'b0010,
        S_READ_ADDR  = 4'b0100,
        S_READ_DATA  = 4'b1000
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [15:0]                  r_idx;
    logic                         r_pending;
    logic                         r_buf_wr_en;
    logic [DW-1:0]                r_buf_wr_data;
    logic                         r_frame_done;
    logic                         w_arvalid;
    logic                         w_beat;
    logic                         w_burst_done;
    logic                         w_last_burst;
    logic                         w_space_ok;
    logic                         w_in_read;
    logic [CTRL_ADDR_WIDTH-1:0]   w_araddr;

    assign w_beat       = (r_state == S_READ_DATA) && axi_rvalid;
    assign w_burst_done = w_beat && axi_rlast;
    assign w_last_burst = (r_idx == FRAME_BURSTS - 16'd1);
    assign w_space_ok   = (buf_space >= BUF_DEPTH_AW'(16));
    assign w_in_read    = (r_state == S_READ_ADDR) || (r_state == S_READ_DATA);
    // Wraps modulo 2^CTRL_ADDR_WIDTH by construction of the operand widths.
    assign w_araddr     = AXI_RADDR_BASE + CTRL_ADDR_WIDTH'(r_idx) * BURST_ADDR_STEP;

    always_ff @(posedge core_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ddr_init_done && rd_en) w_next = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                if (!rd_en)                           w_next = S_IDLE;
                else if (ddr_init_done && w_space_ok) w_next = S_READ_ADDR;
            end
            S_READ_ADDR: begin
                w_arvalid = 1'b1;
                if (axi_arready) w_next = S_READ_DATA;
            end
            S_READ_DATA: begin
                // rd_en is deliberately ignored here: a burst always runs to rlast.
                if (w_burst_done) w_next = S_WAIT_SPACE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Burst index and deferred restart. A restart requested while a burst is
    // outstanding is held in r_pending and applied when that burst completes.
    always_ff @(posedge core_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_idx     <= '0;
            r_pending <= 1'b0;
        end else if (w_burst_done) begin
            r_pending <= 1'b0;
            if (r_pending || frame_start || w_last_burst) r_idx <= '0;
            else                                          r_idx <= r_idx + 16'd1;
        end else if (frame_start) begin
            if (w_in_read) r_pending <= 1'b1;
            else           r_idx     <= '0;
        end
    end

    // frame_done is registered alongside the last buffer write so they coincide;
    // any restart (pending or same-cycle) suppresses it.
    always_ff @(posedge core_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_data <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_buf_wr_en  <= w_beat;
            r_frame_done <= w_burst_done && w_last_burst && !r_pending && !frame_start;
            if (w_beat) r_buf_wr_data <= axi_rdata;
        end
    end

    assign axi_arvalid = w_arvalid;
    assign axi_arlen   = w_arvalid ? 4'hf : 4'h0;
    assign axi_araddr  = w_arvalid ? w_araddr : '0;
    assign buf_wr_en   = r_buf_wr_en;
    assign buf_wr_data = r_buf_wr_data;
    assign frame_done  = r_frame_done;

`ifdef VIDEO_READBACK_LEN_CHECK_EN
    // r_beat_cnt holds the number of beats already received in this burst, so
    // the current beat is the 16th exactly when it reads 15.
    logic [4:0] r_beat_cnt;
    logic       r_rd_err;

    always_ff @(posedge core_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_beat_cnt <= '0;
            r_rd_err   <= 1'b0;
        end else if (w_beat) begin
            if (axi_rlast) begin
                r_beat_cnt <= '0;
                if (r_beat_cnt != 5'd15) r_rd_err <= 1'b1;
            end else begin
                if (r_beat_cnt == 5'd15) r_rd_err <= 1'b1;
                r_beat_cnt <= r_beat_cnt + 5'd1;
            end
        end
    end

    assign rd_err = r_rd_err;
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_video_readback.sv
// tb_video_readback: directed test of video_readback with FRAME_BURSTS=4 and an
// AXI read responder driven from tasks; inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.

module tb_video_readback;

    localparam int AW  = 28;
    localparam int DQ  = 32;
    localparam int DW  = DQ * 8;
    localparam int BAW = 10;

`ifdef VIDEO_READBACK_LEN_CHECK_EN
    localparam logic EXP_LEN_ERR = 1'b1;
`else
    localparam logic EXP_LEN_ERR = 1'b0;
`endif

    logic            core_clk = 1'b0;
    logic            ddr_rst;
    logic            ddr_init_done;
    logic            rd_en;
    logic            frame_start;
    logic [BAW-1:0]  buf_space;
    logic [AW-1:0]   axi_araddr;
    logic [3:0]      axi_arlen;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [DW-1:0]   axi_rdata;
    logic            axi_rvalid;
    logic            axi_rlast;
    logic            buf_wr_en;
    logic [DW-1:0]   buf_wr_data;
    logic            frame_done;
    logic            rd_err;

    int n_checks = 0;
    int n_errors = 0;

    video_readback #(
        .CTRL_ADDR_WIDTH (AW),
        .MEM_DQ_WIDTH    (DQ),
        .FRAME_BURSTS    (16'd4),
        .BUF_DEPTH_AW    (BAW)
    ) u_dut (
        .core_clk      (core_clk),
        .ddr_rst       (ddr_rst),
        .ddr_init_done (ddr_init_done),
        .rd_en         (rd_en),
        .frame_start   (frame_start),
        .buf_space     (buf_space),
        .axi_araddr    (axi_araddr),
        .axi_arlen     (axi_arlen),
        .axi_arvalid   (axi_arvalid),
        .axi_arready   (axi_arready),
        .axi_rdata     (axi_rdata),
        .axi_rvalid    (axi_rvalid),
        .axi_rlast     (axi_rlast),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_data   (buf_wr_data),
        .frame_done    (frame_done),
        .rd_err        (rd_err)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int v);
        logic [31:0] w;
        w = 32'(v);
        return {8{w}};
    endfunction

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic wait_ar(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (axi_arvalid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check({tag, "_ar_timeout"}, 0, 1);
    endtask

    // One burst: wait for the request, check it, handshake (arready must be 1),
    // then feed n_beats beats; rlast goes with the final one.
    task automatic do_burst(input string tag, input int exp_addr, input int n_beats,
                            input int data_base, input int gap_at, input int fs_at,
                            input bit exp_fd);
        bit ok;
        wait_ar(tag, ok);
        if (!ok) return;
        check({tag, "_araddr"}, axi_araddr, exp_addr);
        check({tag, "_arlen"}, axi_arlen, 4'hf);
        step();
        check({tag, "_arvalid_low"}, axi_arvalid, 0);
        for (int i = 0; i < n_beats; i++) begin
            if (i == gap_at) begin
                axi_rvalid = 1'b0;
                step();
                check({tag, "_gap_wr_en"}, buf_wr_en, 0);
            end
            axi_rvalid  = 1'b1;
            axi_rdata   = pat(data_base + i);
            axi_rlast   = (i == n_beats - 1);
            frame_start = (i == fs_at);
            step();
            frame_start = 1'b0;
            check({tag, "_wr_en"}, buf_wr_en, 1);
            check({tag, "_wr_data"}, buf_wr_data, pat(data_base + i));
            check({tag, "_frame_done"}, frame_done, (i == n_beats - 1) ? exp_fd : 1'b0);
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        ddr_rst       = 1'b1;
        ddr_init_done = 1'b1;
        rd_en         = 1'b1;
        frame_start   = 1'b0;
        buf_space     = BAW'(512);
        axi_arready   = 1'b1;
        axi_rdata     = '0;
        axi_rvalid    = 1'b0;
        axi_rlast     = 1'b0;

        step();
        step();
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_araddr", axi_araddr, 0);
        check("rst_arlen", axi_arlen, 0);
        check("rst_wr_en", buf_wr_en, 0);
        check("rst_wr_data", buf_wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_err", rd_err, 0);
        ddr_rst = 1'b0;

        // Index 0: data 0..15 with one idle cycle before beat 5.
        do_burst("b0", 0, 16, 0, 5, -1, 1'b0);

        // Index 1: request held for 5 cycles with arready low.
        axi_arready = 1'b0;
        wait_ar("b1_stall", ok);
        for (int k = 0; k < 5; k++) begin
            check("stall_arvalid", axi_arvalid, 1);
            check("stall_araddr", axi_araddr, 128);
            check("stall_arlen", axi_arlen, 4'hf);
            step();
        end
        axi_arready = 1'b1;
        do_burst("b1", 128, 16, 100, -1, -1, 1'b0);

        // Not enough buffer space: no request until buf_space reaches 16.
        buf_space = BAW'(15);
        for (int k = 0; k < 3; k++) begin
            step();
            check("space15_arvalid", axi_arvalid, 0);
        end
        buf_space = BAW'(16);
        step();
        check("space16_arvalid", axi_arvalid, 1);
        buf_space = BAW'(512);
        do_burst("b2", 256, 16, 200, -1, -1, 1'b0);

        // Last burst of the frame, then wrap.
        do_burst("b3", 384, 16, 300, -1, -1, 1'b1);
        do_burst("b4", 0, 16, 400, -1, -1, 1'b0);

        // Restart during beat 7 of index 1: burst completes, index returns to 0.
        do_burst("b5", 128, 16, 500, -1, 7, 1'b0);
        do_burst("b6", 0, 16, 600, -1, -1, 1'b0);
        do_burst("b7", 128, 16, 700, -1, -1, 1'b0);
        do_burst("b8", 256, 16, 800, -1, -1, 1'b0);

        // Restart coinciding with completion of the frame's last burst.
        do_burst("b9", 384, 16, 900, -1, 15, 1'b0);

        // Short burst: rlast on the 12th beat.
        do_burst("b10", 0, 12, 1000, -1, -1, 1'b0);
        check("short_rd_err", rd_err, EXP_LEN_ERR);
        do_burst("b11", 128, 16, 1100, -1, -1, 1'b0);
        check("sticky_rd_err", rd_err, EXP_LEN_ERR);

        // Asynchronous reset in the middle of a burst.
        wait_ar("b12", ok);
        check("b12_araddr", axi_araddr, 256);
        step();
        for (int i = 0; i < 3; i++) begin
            axi_rvalid = 1'b1;
            axi_rdata  = pat(1200 + i);
            step();
        end
        #2 ddr_rst = 1'b1;
        #1;
        check("arst_wr_en", buf_wr_en, 0);
        check("arst_wr_data", buf_wr_data, 0);
        check("arst_arvalid", axi_arvalid, 0);
        check("arst_rd_err", rd_err, 0);
        axi_rvalid = 1'b0;
        step();
        step();
        ddr_rst = 1'b0;
        do_burst("b13", 0, 16, 1300, -1, -1, 1'b0);

        // rd_en low: back to idle, stray rvalid produces no buffer write.
        rd_en = 1'b0;
        step();
        step();
        axi_rvalid = 1'b1;
        axi_rdata  = pat(77);
        step();
        check("idle_rvalid_wr_en", buf_wr_en, 0);
        check("idle_arvalid", axi_arvalid, 0);
        axi_rvalid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/video_readback.md
Name: video_readback

Overview:
- AXI read master that fetches stored video frame data back out of DDR3 in fixed 16-beat bursts.
- Pushes each beat into a downstream line buffer for the HDMI/Ethernet output path.
- Direct downstream consumer of the DDR frame-write stage.
- Runs entirely in the DDR controller core clock domain.

Parameters:
CTRL_ADDR_WIDTH, 28, AXI address width.
MEM_DQ_WIDTH, 32, DDR DQ width; AXI data bus is MEM_DQ_WIDTH*8 bits.
AXI_RADDR_BASE, 28'd0, frame base address (same region the write stage fills).
BURST_ADDR_STEP, 28'd128, araddr increment per 16-beat burst.
FRAME_BURSTS, 16'd4096, bursts per frame; must be >= 1.
BUF_DEPTH_AW, 10, width of the downstream buffer free-space count.

Ports:
core_clk  in  1  core clock, rising edge.
ddr_rst  in  1  asynchronous reset, active-high.
ddr_init_done  in  1  DDR calibrated; gates all AXI activity.
rd_en  in  1  level enable for readback.
frame_start  in  1  one-cycle pulse: restart at AXI_RADDR_BASE.
buf_space  in  BUF_DEPTH_AW  free words in downstream buffer.
axi_araddr  out  CTRL_ADDR_WIDTH  read address.
axi_arlen  out  4  burst length minus one.
axi_arvalid  out  1  address valid.
axi_arready  in  1  address accepted.
axi_rdata  in  MEM_DQ_WIDTH*8  read data.
axi_rvalid  in  1  read beat valid.
axi_rlast  in  1  last beat of burst.
buf_wr_en  out  1  write strobe to downstream buffer.
buf_wr_data  out  MEM_DQ_WIDTH*8  beat data.
frame_done  out  1  one-cycle pulse after the last beat of a frame.
rd_err  out  1  sticky burst-length error (see Optional Feature).

Behaviour:
- Reset: all outputs 0; state S_IDLE; burst index 0; pending-restart flag 0.
- State machine, one-hot:
  - S_IDLE -> S_WAIT_SPACE when ddr_init_done && rd_en.
  - S_WAIT_SPACE -> S_READ_ADDR when buf_space >= 16 && rd_en && ddr_init_done. Drops rd_en returns to S_IDLE.
  - S_READ_ADDR: axi_arvalid=1, axi_arlen=4'hf, axi_araddr=AXI_RADDR_BASE + index*BURST_ADDR_STEP. All three stay stable until axi_arvalid && axi_arready. On handshake, arvalid falls the next cycle; go to S_READ_DATA.
  - S_READ_DATA: each cycle with axi_rvalid, register buf_wr_en=1 and buf_wr_data=axi_rdata (1-cycle latency); otherwise buf_wr_en=0. On axi_rvalid && axi_rlast -> S_WAIT_SPACE.
  - rd_en deasserted mid-burst never aborts; the burst completes first.
- Indexing:
  - Burst index increments on each completed burst.
  - At the completion of index FRAME_BURSTS-1, index wraps to 0 and frame_done pulses, aligned with the last buf_wr_en.
- frame_start:
  - In S_IDLE or S_WAIT_SPACE: index clears to 0 the next cycle.
  - In S_READ_ADDR or S_READ_DATA: a pending flag is set; the burst finishes; index clears instead of incrementing; no frame_done.
  - frame_start coinciding with the last-frame burst completion: index becomes 0, frame_done is suppressed.
- Address arithmetic: computed in CTRL_ADDR_WIDTH bits; overflow wraps modulo 2^CTRL_ADDR_WIDTH.
- buf_space is sampled only in S_WAIT_SPACE; the downstream buffer must guarantee 16 free words remain once the burst is granted.
- axi_rvalid outside S_READ_DATA is ignored (no buf_wr_en).
- Async reset mid-burst: immediate return to reset values. The controller must be reset together with this block.

Optional Feature:
Macro VIDEO_READBACK_LEN_CHECK_EN.
- Defined:
  - A 5-bit beat counter runs in S_READ_DATA.
  - rd_err sets (sticky until reset) if rlast arrives on a beat other than the 16th, or if a 16th beat arrives without rlast.
  - State advances on rlast as normal.
- Undefined: no counter; rd_err tied to 0.

Test Plan:
- Reset, ddr_init_done=1, rd_en=1, buf_space=512, arready=1 -> first araddr=0, arlen=4'hf. 16 rvalid beats with data 0..15 -> buf_wr_data 0..15, each 1 cycle after its beat. Second burst araddr=128.
- arready held 0 for 5 cycles -> arvalid stays 1; araddr/arlen stay stable for all 5 cycles; exactly one burst is issued.
- buf_space=15 -> stays in S_WAIT_SPACE with arvalid=0; raising it to 16 -> arvalid on the next cycle.
- FRAME_BURSTS=2, continuous run -> araddr sequence 0,128,0,128. frame_done pulses once per 32 beats, coincident with the last buf_wr_en.
- frame_start pulse during beat 7 of the burst at index 1 (FRAME_BURSTS=4) -> burst completes all 16 beats; next araddr=0; no frame_done.
- With VIDEO_READBACK_LEN_CHECK_EN, rlast on the 12th beat -> rd_err=1 the next cycle and held. The next burst still issues at the next address.
